// File: rtl/order_book_matcher_if.sv
// Order-entry, trade and book-status bundle for the order book matcher.
// The master drives orders and trade_ready; the slave is the matcher itself.
interface order_book_matcher_if #(
   parameter int PW    = 8,
   parameter int QW    = 8,
   parameter int DEPTH = 8
);
   localparam int CW = $clog2(DEPTH+1);

   logic          buy_valid;
   logic          buy_ready;
   logic [PW-1:0] buy_price;
   logic [QW-1:0] buy_qty;
   logic          sell_valid;
   logic          sell_ready;
   logic [PW-1:0] sell_price;
   logic [QW-1:0] sell_qty;
   logic          trade_valid;
   logic          trade_ready;
   logic [PW-1:0] trade_price;
   logic [QW-1:0] trade_qty;
   logic [PW-1:0] best_bid;
   logic [PW-1:0] best_ask;
   logic [CW-1:0] bid_count;
   logic [CW-1:0] ask_count;

   modport master (
      output buy_valid, buy_price, buy_qty, sell_valid, sell_price, sell_qty, trade_ready,
      input  buy_ready, sell_ready, trade_valid, trade_price, trade_qty,
             best_bid, best_ask, bid_count, ask_count
   );

   modport slave (
      input  buy_valid, buy_price, buy_qty, sell_valid, sell_price, sell_qty, trade_ready,
      output buy_ready, sell_ready, trade_valid, trade_price, trade_qty,
             best_bid, best_ask, bid_count, ask_count
   );
endinterface

// File: rtl/order_book_matcher.sv
// Limit-order book with DEPTH bid/ask slots; emits one partial-fill trade at a time
// whenever the best bid crosses the best ask.
module order_book_matcher #(
   parameter int PW    = 8,
   parameter int QW    = 8,
   parameter int DEPTH = 8
) (
   input logic                 clk,
   input logic                 reset,
   order_book_matcher_if.slave ob
);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   typedef enum logic {IDLE, EMIT} state_e;

   state_e                   state_q, state_d;
   logic [DEPTH-1:0]         bid_v_q, ask_v_q;
   logic [DEPTH-1:0][PW-1:0] bid_px_q, ask_px_q;
   logic [DEPTH-1:0][QW-1:0] bid_qty_q, ask_qty_q;
   logic [PW-1:0]            trade_px_q, trade_px_d;
   logic [QW-1:0]            trade_qty_q, trade_qty_d;
   logic [IW-1:0]            bid_idx_q, bid_idx_d, ask_idx_q, ask_idx_d;

   logic [PW-1:0] bb_px, ba_px;
   logic [QW-1:0] bb_qty, ba_qty;
   logic [IW-1:0] bb_idx, ba_idx, bid_free, ask_free;
   logic          bb_any, ba_any;
   logic [CW-1:0] bid_cnt, ask_cnt;
   logic [PW:0]   px_sum;
   logic          fill, buy_wr, sell_wr;

   // Best-price search; strict compares keep ties on the lowest slot index.
   always_comb begin
      bb_px  = '0;
      bb_qty = '0;
      bb_idx = '0;
      bb_any = 1'b0;
      ba_px  = '1;
      ba_qty = '0;
      ba_idx = '0;
      ba_any = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (bid_v_q[i] && (!bb_any || bid_px_q[i] > bb_px)) begin
            bb_any = 1'b1;
            bb_px  = bid_px_q[i];
            bb_qty = bid_qty_q[i];
            bb_idx = IW'(i);
         end
         if (ask_v_q[i] && (!ba_any || ask_px_q[i] < ba_px)) begin
            ba_any = 1'b1;
            ba_px  = ask_px_q[i];
            ba_qty = ask_qty_q[i];
            ba_idx = IW'(i);
         end
      end
   end

   always_comb begin
      bid_free = '0;
      ask_free = '0;
      bid_cnt  = '0;
      ask_cnt  = '0;
      for (int i = DEPTH-1; i >= 0; i--) begin
         if (!bid_v_q[i]) bid_free = IW'(i);
         if (!ask_v_q[i]) ask_free = IW'(i);
         bid_cnt = bid_cnt + CW'(bid_v_q[i]);
         ask_cnt = ask_cnt + CW'(ask_v_q[i]);
      end
   end

   assign ob.buy_ready   = (bid_cnt < CW'(DEPTH));
   assign ob.sell_ready  = (ask_cnt < CW'(DEPTH));
   assign ob.bid_count   = bid_cnt;
   assign ob.ask_count   = ask_cnt;
   assign ob.best_bid    = bb_px;
   assign ob.best_ask    = ba_px;
   assign ob.trade_valid = (state_q == EMIT);
   assign ob.trade_price = trade_px_q;
   assign ob.trade_qty   = trade_qty_q;

   // Zero-quantity orders complete the handshake but never occupy a slot.
   assign buy_wr  = ob.buy_valid  && ob.buy_ready  && (ob.buy_qty  != '0);
   assign sell_wr = ob.sell_valid && ob.sell_ready && (ob.sell_qty != '0);
   assign px_sum  = {1'b0, bb_px} + {1'b0, ba_px};

   always_comb begin
      state_d     = state_q;
      trade_px_d  = trade_px_q;
      trade_qty_d = trade_qty_q;
      bid_idx_d   = bid_idx_q;
      ask_idx_d   = ask_idx_q;
      fill        = 1'b0;
      case (state_q)
         IDLE: begin
            if (bb_any && ba_any && (bb_px >= ba_px)) begin
               state_d     = EMIT;
               trade_px_d  = px_sum[PW:1];
               trade_qty_d = (bb_qty < ba_qty) ? bb_qty : ba_qty;
               bid_idx_d   = bb_idx;
               ask_idx_d   = ba_idx;
            end
         end
         EMIT: begin
            if (ob.trade_ready) begin
               state_d = IDLE;
               fill    = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         trade_px_q  <= '0;
         trade_qty_q <= '0;
         bid_idx_q   <= '0;
         ask_idx_q   <= '0;
      end else begin
         state_q     <= state_d;
         trade_px_q  <= trade_px_d;
         trade_qty_q <= trade_qty_d;
         bid_idx_q   <= bid_idx_d;
         ask_idx_q   <= ask_idx_d;
      end
   end

   // Inserts only target free slots, so they never collide with the latched fill slots.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bid_v_q   <= '0;
         ask_v_q   <= '0;
         bid_px_q  <= '0;
         ask_px_q  <= '0;
         bid_qty_q <= '0;
         ask_qty_q <= '0;
      end else begin
         if (buy_wr) begin
            bid_v_q[bid_free]   <= 1'b1;
            bid_px_q[bid_free]  <= ob.buy_price;
            bid_qty_q[bid_free] <= ob.buy_qty;
         end
         if (sell_wr) begin
            ask_v_q[ask_free]   <= 1'b1;
            ask_px_q[ask_free]  <= ob.sell_price;
            ask_qty_q[ask_free] <= ob.sell_qty;
         end
         if (fill) begin
            bid_qty_q[bid_idx_q] <= bid_qty_q[bid_idx_q] - trade_qty_q;
            ask_qty_q[ask_idx_q] <= ask_qty_q[ask_idx_q] - trade_qty_q;
            if (bid_qty_q[bid_idx_q] == trade_qty_q) bid_v_q[bid_idx_q] <= 1'b0;
            if (ask_qty_q[ask_idx_q] == trade_qty_q) ask_v_q[ask_idx_q] <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_order_book_matcher.sv
// Bench for order_book_matcher: directed vector table, hand-written corner sequences,
// and random order flow scored against a slot-level book model.
module tb_order_book_matcher;
   localparam int PW    = 8;
   localparam int QW    = 8;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   order_book_matcher_if #(.PW(PW), .QW(QW), .DEPTH(DEPTH)) ob();

   order_book_matcher #(.PW(PW), .QW(QW), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .ob    (ob.slave)
   );

   always #5 clk = ~clk;

   // Book model, side index 1 = bids, 0 = asks.
   bit bk_v[2][DEPTH];
   int bk_p[2][DEPTH];
   int bk_q[2][DEPTH];

   typedef struct {
      bit   buy;
      int   px;
      int   qty;
      bit   tr;
      int   tpx;
      int   tqty;
      int   bc;
      int   ac;
      int   bb;
      int   ba;
   } vec_t;

   vec_t vt[15];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic void m_clear();
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < DEPTH; i++) begin
            bk_v[s][i] = 1'b0;
            bk_p[s][i] = 0;
            bk_q[s][i] = 0;
         end
   endfunction

   function automatic int m_cnt(input int s);
      int c = 0;
      for (int i = 0; i < DEPTH; i++) if (bk_v[s][i]) c++;
      return c;
   endfunction

   function automatic void m_add(input int s, input int px, input int q);
      if (q == 0) return;
      for (int i = 0; i < DEPTH; i++)
         if (!bk_v[s][i]) begin
            bk_v[s][i] = 1'b1;
            bk_p[s][i] = px;
            bk_q[s][i] = q;
            return;
         end
   endfunction

   // Highest bid / lowest ask, earliest slot on ties; -1 when the side is empty.
   function automatic int m_best(input int s);
      int b = -1;
      for (int i = 0; i < DEPTH; i++)
         if (bk_v[s][i] && (b < 0 || (s == 1 ? bk_p[s][i] > bk_p[s][b] : bk_p[s][i] < bk_p[s][b])))
            b = i;
      return b;
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      ob.buy_valid = 1'b0;
      ob.sell_valid = 1'b0;
      ob.trade_ready = 1'b0;
      m_clear();
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic send(input bit buy, input int px, input int q);
      if (buy) begin
         ob.buy_valid = 1'b1;
         ob.buy_price = PW'(px);
         ob.buy_qty   = QW'(q);
      end else begin
         ob.sell_valid = 1'b1;
         ob.sell_price = PW'(px);
         ob.sell_qty   = QW'(q);
      end
      @(posedge clk); #1;
      ob.buy_valid  = 1'b0;
      ob.sell_valid = 1'b0;
   endtask

   task automatic wait_trade(output bit got);
      got = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (ob.trade_valid) begin
            got = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic handshake();
      ob.trade_ready = 1'b1;
      @(posedge clk); #1;
      ob.trade_ready = 1'b0;
   endtask

   task automatic quiet(input string nm);
      repeat (2) begin
         @(posedge clk); #1;
      end
      chk({nm, "_no_trade"}, ob.trade_valid, 0);
   endtask

   task automatic check_book(input string nm, input int bc, input int ac, input int bb, input int ba);
      chk({nm, "_bid_count"}, ob.bid_count, bc);
      chk({nm, "_ask_count"}, ob.ask_count, ac);
      chk({nm, "_best_bid"}, ob.best_bid, bb);
      chk({nm, "_best_ask"}, ob.best_ask, ba);
   endtask

   // Drain every crossing the model predicts, comparing each emitted trade.
   task automatic resolve(input string nm);
      int bi, ai, ep, eq;
      bit got;
      for (int g = 0; g < 2*DEPTH+2; g++) begin
         bi = m_best(1);
         ai = m_best(0);
         if (bi < 0 || ai < 0 || bk_p[1][bi] < bk_p[0][ai]) break;
         ep = (bk_p[1][bi] + bk_p[0][ai]) / 2;
         eq = (bk_q[1][bi] < bk_q[0][ai]) ? bk_q[1][bi] : bk_q[0][ai];
         wait_trade(got);
         chk({nm, "_trade_valid"}, got, 1);
         chk({nm, "_trade_price"}, ob.trade_price, ep);
         chk({nm, "_trade_qty"}, ob.trade_qty, eq);
         handshake();
         bk_q[1][bi] -= eq;
         bk_q[0][ai] -= eq;
         if (bk_q[1][bi] == 0) bk_v[1][bi] = 1'b0;
         if (bk_q[0][ai] == 0) bk_v[0][ai] = 1'b0;
      end
      quiet(nm);
   endtask

   initial begin
      bit got;
      int bb_e, ba_e, side, px, q;
      ob.buy_valid = 1'b0;
      ob.sell_valid = 1'b0;
      ob.trade_ready = 1'b0;
      ob.buy_price = '0;
      ob.buy_qty = '0;
      ob.sell_price = '0;
      ob.sell_qty = '0;

      vt[0]  = '{1, 100, 5,  0, 0,   0, 1, 0, 100, 255};
      vt[1]  = '{0,  90, 5,  1, 95,  5, 0, 0,   0, 255};
      vt[2]  = '{1, 100, 10, 0, 0,   0, 1, 0, 100, 255};
      vt[3]  = '{0,  98, 4,  1, 99,  4, 1, 0, 100, 255};
      vt[4]  = '{0,  99, 3,  1, 99,  3, 1, 0, 100, 255};
      vt[5]  = '{0, 101, 3,  0, 0,   0, 1, 1, 100, 101};
      vt[6]  = '{1, 101, 3,  1, 101, 3, 1, 0, 100, 255};
      vt[7]  = '{0, 100, 3,  1, 100, 3, 0, 0,   0, 255};
      vt[8]  = '{1, 255, 1,  0, 0,   0, 1, 0, 255, 255};
      vt[9]  = '{0, 255, 1,  1, 255, 1, 0, 0,   0, 255};
      vt[10] = '{1,  50, 0,  0, 0,   0, 0, 0,   0, 255};
      vt[11] = '{0,  40, 0,  0, 0,   0, 0, 0,   0, 255};
      vt[12] = '{0,   0, 2,  0, 0,   0, 0, 1,   0,   0};
      vt[13] = '{1,   0, 1,  1, 0,   1, 0, 1,   0,   0};
      vt[14] = '{1,   1, 1,  1, 0,   1, 0, 0,   0, 255};

      do_reset();
      chk("rst_trade_valid", ob.trade_valid, 0);
      chk("rst_trade_price", ob.trade_price, 0);
      chk("rst_trade_qty", ob.trade_qty, 0);
      chk("rst_buy_ready", ob.buy_ready, 1);
      chk("rst_sell_ready", ob.sell_ready, 1);
      check_book("rst", 0, 0, 0, 255);

      for (int v = 0; v < 15; v++) begin
         send(vt[v].buy, vt[v].px, vt[v].qty);
         if (vt[v].tr) begin
            wait_trade(got);
            chk($sformatf("vec%0d_trade_valid", v), got, 1);
            chk($sformatf("vec%0d_trade_price", v), ob.trade_price, vt[v].tpx);
            chk($sformatf("vec%0d_trade_qty", v), ob.trade_qty, vt[v].tqty);
            handshake();
         end
         quiet($sformatf("vec%0d", v));
         check_book($sformatf("vec%0d", v), vt[v].bc, vt[v].ac, vt[v].bb, vt[v].ba);
      end

      // Stalled trade: fields hold, inserts still land, release fills exactly once.
      do_reset();
      send(1, 100, 5);
      send(0, 90, 3);
      wait_trade(got);
      chk("hold_seen", got, 1);
      for (int k = 0; k < 5; k++) begin
         chk("hold_valid", ob.trade_valid, 1);
         chk("hold_price", ob.trade_price, 95);
         chk("hold_qty", ob.trade_qty, 3);
         if (k == 1) send(1, 80, 2);
         else begin
            @(posedge clk); #1;
         end
      end
      chk("hold_bid_count", ob.bid_count, 2);
      handshake();
      chk("hold_released", ob.trade_valid, 0);
      check_book("hold_after", 2, 0, 100, 255);
      send(0, 100, 2);
      wait_trade(got);
      chk("hold_rem_seen", got, 1);
      chk("hold_rem_price", ob.trade_price, 100);
      chk("hold_rem_qty", ob.trade_qty, 2);
      handshake();
      quiet("hold_rem");
      check_book("hold_rem", 1, 0, 80, 255);

      // Full bid book: backpressure, then one fill reopens it.
      do_reset();
      for (int k = 0; k < DEPTH; k++) begin
         chk("full_ready_open", ob.buy_ready, 1);
         send(1, 10 + k, 1);
      end
      chk("full_ready_closed", ob.buy_ready, 0);
      ob.buy_valid = 1'b1;
      ob.buy_price = 8'd18;
      ob.buy_qty = 8'd1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      ob.buy_valid = 1'b0;
      check_book("full_stall", DEPTH, 0, 17, 255);
      send(0, 17, 1);
      wait_trade(got);
      chk("full_trade_seen", got, 1);
      chk("full_trade_price", ob.trade_price, 17);
      handshake();
      chk("full_ready_reopen", ob.buy_ready, 1);
      chk("full_count_after", ob.bid_count, DEPTH - 1);

      // Asynchronous reset mid-trade.
      do_reset();
      send(1, 100, 5);
      send(0, 90, 5);
      wait_trade(got);
      chk("arst_trade_seen", got, 1);
      #2 reset = 1'b1;
      #1;
      chk("arst_trade_valid", ob.trade_valid, 0);
      chk("arst_trade_price", ob.trade_price, 0);
      check_book("arst", 0, 0, 0, 255);
      @(posedge clk); #1;
      reset = 1'b0;

      // Random order flow against the model.
      do_reset();
      for (int n = 0; n < 400; n++) begin
         side = int'($urandom_range(0, 1));
         px   = int'($urandom_range(88, 112));
         q    = int'($urandom_range(0, 9));
         chk("rnd_buy_ready", ob.buy_ready, m_cnt(1) < DEPTH);
         chk("rnd_sell_ready", ob.sell_ready, m_cnt(0) < DEPTH);
         if (m_cnt(side) == DEPTH) side = 1 - side;
         if (m_cnt(side) == DEPTH) begin
            do_reset();
            continue;
         end
         send(side == 1, px, q);
         m_add(side, px, q);
         resolve("rnd");
         bb_e = (m_best(1) < 0) ? 0   : bk_p[1][m_best(1)];
         ba_e = (m_best(0) < 0) ? 255 : bk_p[0][m_best(0)];
         check_book("rnd", m_cnt(1), m_cnt(0), bb_e, ba_e);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
